// File: rtl/inst_fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: per-entry payload and the
// stale-response tracking states.
package inst_fetch_queue_pkg;

  localparam int FETCH_GROUP_BYTES = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } fetch_entry_t;

  typedef enum logic {
    NORMAL = 1'b0,
    DROP   = 1'b1
  } fq_state_e;

endpackage

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: takes 8-byte I-cache groups, buffers single
// instructions with their PCs and presents up to two per cycle to decode.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     fetch_busy,
  input  logic                     resp_valid,
  output logic                     resp_ready,
  input  logic [31:0]              resp_pc,
  input  logic [31:0]              resp_inst0,
  input  logic [31:0]              resp_inst1,
  input  logic                     resp_err,
  input  logic [1:0]               deq_num,
  output logic                     deq0_valid,
  output logic                     deq1_valid,
  output logic [31:0]              deq0_pc,
  output logic [31:0]              deq1_pc,
  output logic [31:0]              deq0_inst,
  output logic [31:0]              deq1_inst,
  output logic                     deq0_err,
  output logic                     deq1_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr1, wr_ptr1;
  fq_state_e        state, state_nxt;
  logic             accept;
  logic [CW-1:0]    enq_n, deq_req, deq_n;

  assign rd_ptr1    = rd_ptr + PTR_W'(1);
  assign wr_ptr1    = wr_ptr + PTR_W'(1);
  assign resp_ready = count <= CW'(DEPTH - 2);
  assign empty      = count == '0;
  assign accept     = resp_valid & resp_ready & ~flush & (state == NORMAL);

  // Odd-word starts carry only the upper instruction of the group.
  always_comb begin
    enq_n   = '0;
    if (accept) enq_n = resp_pc[2] ? CW'(1) : CW'(2);
    deq_req = (deq_num == 2'd3) ? CW'(2) : CW'(deq_num);
    deq_n   = (deq_req > count) ? count : deq_req;
  end

  // A flush while the I-cache still owes a response means that response is
  // from the old path and must be swallowed when it arrives.
  always_comb begin
    state_nxt = state;
    case (state)
      NORMAL: if (flush & fetch_busy & ~resp_valid) state_nxt = DROP;
      DROP: begin
        if (flush)           state_nxt = (fetch_busy & ~resp_valid) ? DROP : NORMAL;
        else if (resp_valid) state_nxt = NORMAL;
      end
      default: state_nxt = NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      state  <= NORMAL;
    end else begin
      state <= state_nxt;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        rd_ptr <= rd_ptr + deq_n[PTR_W-1:0];
        wr_ptr <= wr_ptr + enq_n[PTR_W-1:0];
        count  <= count + enq_n - deq_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if (resp_pc[2]) begin
        mem[wr_ptr] <= '{pc: resp_pc, inst: resp_inst1, err: resp_err};
      end else begin
        mem[wr_ptr]  <= '{pc: resp_pc, inst: resp_inst0, err: resp_err};
        mem[wr_ptr1] <= '{pc: resp_pc + 32'(FETCH_GROUP_BYTES / 2),
                          inst: resp_inst1, err: resp_err};
      end
    end
  end

  // Head data is forced to zero when invalid so reset presents clean outputs.
  assign deq0_valid = count != '0;
  assign deq1_valid = count >= CW'(2);
  assign deq0_pc    = deq0_valid ? mem[rd_ptr].pc    : '0;
  assign deq0_inst  = deq0_valid ? mem[rd_ptr].inst  : '0;
  assign deq0_err   = deq0_valid ? mem[rd_ptr].err   : 1'b0;
  assign deq1_pc    = deq1_valid ? mem[rd_ptr1].pc   : '0;
  assign deq1_inst  = deq1_valid ? mem[rd_ptr1].inst : '0;
  assign deq1_err   = deq1_valid ? mem[rd_ptr1].err  : 1'b0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: vector table plus streaming, wrap and
// asynchronous-reset sequences.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, fetch_busy, resp_valid, resp_err;
  logic        resp_ready;
  logic [31:0] resp_pc, resp_inst0, resp_inst1;
  logic [1:0]  deq_num;
  logic        deq0_valid, deq1_valid, deq0_err, deq1_err, empty;
  logic [31:0] deq0_pc, deq1_pc, deq0_inst, deq1_inst;
  logic [3:0]  count;

  int checks = 0;
  int passed = 0;

  inst_fetch_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fetch_busy(fetch_busy),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_pc(resp_pc),
    .resp_inst0(resp_inst0), .resp_inst1(resp_inst1), .resp_err(resp_err),
    .deq_num(deq_num), .deq0_valid(deq0_valid), .deq1_valid(deq1_valid),
    .deq0_pc(deq0_pc), .deq1_pc(deq1_pc), .deq0_inst(deq0_inst),
    .deq1_inst(deq1_inst), .deq0_err(deq0_err), .deq1_err(deq1_err),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic fl; logic busy; logic rv; logic [31:0] pc; logic [31:0] i0;
    logic [31:0] i1; logic er; logic [1:0] dn;
    int cnt; logic rdy;
    logic v0; logic [31:0] pc0; logic [31:0] in0; logic e0;
    logic v1; logic [31:0] pc1; logic [31:0] in1; logic e1;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic fl, input logic busy, input logic rv,
                       input logic [31:0] pc, input logic [31:0] i0,
                       input logic [31:0] i1, input logic er, input logic [1:0] dn);
    flush = fl; fetch_busy = busy; resp_valid = rv; resp_pc = pc;
    resp_inst0 = i0; resp_inst1 = i1; resp_err = er; deq_num = dn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // fl busy rv pc i0 i1 er dn | cnt rdy | v0 pc0 in0 e0 | v1 pc1 in1 e1
    vecs.push_back('{0,0,1,32'hbfc00000,32'hA,32'hB,0,0, 2,1, 1,32'hbfc00000,32'hA,0, 1,32'hbfc00004,32'hB,0});
    vecs.push_back('{0,0,0,0,0,0,0,2,                     0,1, 0,0,0,0, 0,0,0,0});
    vecs.push_back('{0,0,1,32'hbfc00004,32'hDEAD,32'hC,0,0, 1,1, 1,32'hbfc00004,32'hC,0, 0,0,0,0});
    vecs.push_back('{0,0,0,0,0,0,0,2,                     0,1, 0,0,0,0, 0,0,0,0});
    vecs.push_back('{0,0,0,0,0,0,0,2,                     0,1, 0,0,0,0, 0,0,0,0});
    vecs.push_back('{0,0,1,32'h1000,32'h10,32'h11,0,0,    2,1, 1,32'h1000,32'h10,0, 1,32'h1004,32'h11,0});
    vecs.push_back('{0,0,1,32'h1008,32'h12,32'h13,0,0,    4,1, 1,32'h1000,32'h10,0, 1,32'h1004,32'h11,0});
    vecs.push_back('{0,0,1,32'h1010,32'h14,32'h15,0,0,    6,1, 1,32'h1000,32'h10,0, 1,32'h1004,32'h11,0});
    vecs.push_back('{0,0,1,32'h101c,32'h16,32'h17,0,0,    7,0, 1,32'h1000,32'h10,0, 1,32'h1004,32'h11,0});
    vecs.push_back('{0,0,1,32'h1020,32'h18,32'h19,0,2,    5,1, 1,32'h1008,32'h12,0, 1,32'h100c,32'h13,0});
    vecs.push_back('{0,0,1,32'h1020,32'h18,32'h19,0,2,    5,1, 1,32'h1010,32'h14,0, 1,32'h1014,32'h15,0});
    vecs.push_back('{0,0,0,0,0,0,0,3,                     3,1, 1,32'h101c,32'h17,0, 1,32'h1020,32'h18,0});
    vecs.push_back('{0,0,0,0,0,0,0,1,                     2,1, 1,32'h1020,32'h18,0, 1,32'h1024,32'h19,0});
    vecs.push_back('{1,0,1,32'h2000,32'h1,32'h2,0,2,      0,1, 0,0,0,0, 0,0,0,0});
    vecs.push_back('{0,0,1,32'h3000,32'h30,32'h31,0,0,    2,1, 1,32'h3000,32'h30,0, 1,32'h3004,32'h31,0});
    vecs.push_back('{1,1,0,0,0,0,0,0,                     0,1, 0,0,0,0, 0,0,0,0});
    vecs.push_back('{0,0,1,32'h100,32'h1,32'h2,0,0,       0,1, 0,0,0,0, 0,0,0,0});
    vecs.push_back('{0,0,1,32'h200,32'h20,32'h21,0,0,     2,1, 1,32'h200,32'h20,0, 1,32'h204,32'h21,0});
    vecs.push_back('{0,0,0,0,0,0,0,2,                     0,1, 0,0,0,0, 0,0,0,0});
    vecs.push_back('{0,0,1,32'h8,32'h80,32'h81,1,0,       2,1, 1,32'h8,32'h80,1, 1,32'hc,32'h81,1});
    vecs.push_back('{1,1,0,0,0,0,0,0,                     0,1, 0,0,0,0, 0,0,0,0});
    vecs.push_back('{1,1,0,0,0,0,0,0,                     0,1, 0,0,0,0, 0,0,0,0});
    vecs.push_back('{0,0,1,32'h400,32'h1,32'h2,0,0,       0,1, 0,0,0,0, 0,0,0,0});
    vecs.push_back('{0,0,1,32'h500,32'h50,32'h51,0,0,     2,1, 1,32'h500,32'h50,0, 1,32'h504,32'h51,0});
    vecs.push_back('{1,1,0,0,0,0,0,0,                     0,1, 0,0,0,0, 0,0,0,0});
    vecs.push_back('{1,0,0,0,0,0,0,0,                     0,1, 0,0,0,0, 0,0,0,0});
    vecs.push_back('{0,0,1,32'h600,32'h60,32'h61,0,0,     2,1, 1,32'h600,32'h60,0, 1,32'h604,32'h61,0});
    vecs.push_back('{0,0,1,32'h700,32'h70,32'h71,0,2,     2,1, 1,32'h700,32'h70,0, 1,32'h704,32'h71,0});
    vecs.push_back('{0,0,1,32'h800,32'h90,32'h91,0,0,     4,1, 1,32'h700,32'h70,0, 1,32'h704,32'h71,0});
    vecs.push_back('{0,0,1,32'h808,32'h92,32'h93,0,0,     6,1, 1,32'h700,32'h70,0, 1,32'h704,32'h71,0});
    vecs.push_back('{0,0,1,32'h810,32'h94,32'h95,0,0,     8,0, 1,32'h700,32'h70,0, 1,32'h704,32'h71,0});
    vecs.push_back('{0,0,1,32'h818,32'h96,32'h97,0,2,     6,1, 1,32'h800,32'h90,0, 1,32'h804,32'h91,0});

    rst = 1'b0;
    flush = 0; fetch_busy = 0; resp_valid = 0; resp_pc = 0;
    resp_inst0 = 0; resp_inst1 = 0; resp_err = 0; deq_num = 0;
    #12;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_ready", 32'(resp_ready), 32'd1);
    chk("reset_v0", 32'(deq0_valid), 32'd0);
    chk("reset_v1", 32'(deq1_valid), 32'd0);
    chk("reset_pc0", deq0_pc, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      drive(v.fl, v.busy, v.rv, v.pc, v.i0, v.i1, v.er, v.dn);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(v.cnt));
      chk($sformatf("v%0d_ready", i), 32'(resp_ready), 32'(v.rdy));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(v.cnt == 0));
      chk($sformatf("v%0d_v0", i), 32'(deq0_valid), 32'(v.v0));
      chk($sformatf("v%0d_v1", i), 32'(deq1_valid), 32'(v.v1));
      if (v.v0) begin
        chk($sformatf("v%0d_pc0", i), deq0_pc, v.pc0);
        chk($sformatf("v%0d_inst0", i), deq0_inst, v.in0);
        chk($sformatf("v%0d_err0", i), 32'(deq0_err), 32'(v.e0));
      end
      if (v.v1) begin
        chk($sformatf("v%0d_pc1", i), deq1_pc, v.pc1);
        chk($sformatf("v%0d_inst1", i), deq1_inst, v.in1);
        chk($sformatf("v%0d_err1", i), 32'(deq1_err), 32'(v.e1));
      end
    end

    // Stream 20 groups through an 8-entry queue so both pointers wrap.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_stream_count", 32'(count), 32'd0);
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 1, 32'h8000 + 32'(8 * k), 32'h1000 + 32'(2 * k),
            32'h1001 + 32'(2 * k), 0, (k == 0) ? 2'd0 : 2'd2);
      chk($sformatf("s%0d_count", k), 32'(count), 32'd2);
      chk($sformatf("s%0d_pc0", k), deq0_pc, 32'h8000 + 32'(8 * k));
      chk($sformatf("s%0d_inst0", k), deq0_inst, 32'h1000 + 32'(2 * k));
      chk($sformatf("s%0d_pc1", k), deq1_pc, 32'h8004 + 32'(8 * k));
      chk($sformatf("s%0d_inst1", k), deq1_inst, 32'h1001 + 32'(2 * k));
    end

    // Asynchronous reset between edges with entries buffered.
    flush = 0; resp_valid = 0; deq_num = 0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_v0", 32'(deq0_valid), 32'd0);
    chk("async_rst_empty", 32'(empty), 32'd1);
    chk("async_rst_ready", 32'(resp_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 1, 32'h9000, 32'h55, 32'h66, 0, 0);
    chk("post_rst_count", 32'(count), 32'd2);
    chk("post_rst_pc0", deq0_pc, 32'h9000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
